// File: rtl/rx_ctrl_module.sv
// UART receive sequencer: synchronises the RX line, gates the baud counter,
// assembles an LSB-first frame and hands the byte over a valid/ready handshake.
module rx_ctrl_module #(
  parameter int DATA_BITS = 8
) (
  input  logic                 CLK,
  input  logic                 RST_n,
  input  logic                 RX_Pin_In,
  input  logic                 BPS_CLK,
  output logic                 Count_Sig,
  output logic [DATA_BITS-1:0] RX_Data,
  output logic                 RX_Valid,
  input  logic                 RX_Ready,
  output logic                 Frame_Err,
  output logic                 Overrun
);

  localparam int CW = $clog2(DATA_BITS);
  localparam logic [CW-1:0] LAST_BIT = CW'(DATA_BITS - 1);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t               state;
  logic                 sync1;
  logic                 sync2;
  logic                 rx_prev;
  logic                 fall;
  logic [DATA_BITS-1:0] shift;
  logic [CW-1:0]        bit_cnt;

  // Sync flops reset to the idle-high line level so reset release never looks like a start bit.
  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      sync1   <= 1'b1;
      sync2   <= 1'b1;
      rx_prev <= 1'b1;
    end else begin
      // NOTE: non-blocking assignments make each stage read the previous stage's old value,
      // which is what turns these three lines into a shift chain rather than a single wire.
      sync1   <= RX_Pin_In;
      sync2   <= sync1;
      rx_prev <= sync2;
    end
  end

  assign fall = rx_prev & ~sync2;

  always_ff @(posedge CLK or negedge RST_n) begin
    if (!RST_n) begin
      state     <= IDLE;
      Count_Sig <= 1'b0;
      RX_Data   <= '0;
      RX_Valid  <= 1'b0;
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
      shift     <= '0;
      bit_cnt   <= '0;
    end else begin
      Frame_Err <= 1'b0;
      Overrun   <= 1'b0;
      // NOTE: this default clear is overridden by the later load in STOP when a new byte
      // arrives in the same cycle; the last non-blocking assignment in the block wins.
      if (RX_Valid && RX_Ready) RX_Valid <= 1'b0;

      case (state)
        IDLE: begin
          if (fall) begin
            state     <= START;
            Count_Sig <= 1'b1;
          end
        end

        START: begin
          if (BPS_CLK) begin
            if (sync2) begin
              // Line back high at mid-start-bit: a glitch, drop it silently.
              state     <= IDLE;
              Count_Sig <= 1'b0;
            end else begin
              state   <= DATA;
              bit_cnt <= '0;
            end
          end
        end

        DATA: begin
          if (BPS_CLK) begin
            shift   <= {sync2, shift[DATA_BITS-1:1]};
            bit_cnt <= bit_cnt + CW'(1);
            if (bit_cnt == LAST_BIT) state <= STOP;
          end
        end

        STOP: begin
          if (BPS_CLK) begin
            state     <= IDLE;
            Count_Sig <= 1'b0;
            if (!sync2) begin
              Frame_Err <= 1'b1;
            end else if (!RX_Valid || RX_Ready) begin
              RX_Data  <= shift;
              RX_Valid <= 1'b1;
            end else begin
              Overrun <= 1'b1;
            end
          end
        end

        default: begin
          state     <= IDLE;
          Count_Sig <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_rx_ctrl_module.sv
// Bench for rx_ctrl_module: behavioural baud counter, serial line driver,
// table-driven frames, hand-written corner sequences and a randomized scoreboard run.
module tb_rx_ctrl_module;

  logic       clk;
  logic       rst_n;
  logic       rx_pin;
  logic       bps_clk;
  logic       count_sig;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  int errors = 0;
  int checks = 0;

  // Baud counter stand-in: 0..bps_full while enabled, mid-bit pulse at bps_full/2.
  int bps_full = 434;
  int bcnt;

  rx_ctrl_module #(.DATA_BITS(8)) dut (
    .CLK       (clk),
    .RST_n     (rst_n),
    .RX_Pin_In (rx_pin),
    .BPS_CLK   (bps_clk),
    .Count_Sig (count_sig),
    .RX_Data   (rx_data),
    .RX_Valid  (rx_valid),
    .RX_Ready  (rx_ready),
    .Frame_Err (frame_err),
    .Overrun   (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n)                bcnt <= 0;
    else if (!count_sig)       bcnt <= 0;
    else if (bcnt == bps_full) bcnt <= 0;
    else                       bcnt <= bcnt + 1;
  end

  assign bps_clk = count_sig && (bcnt == bps_full / 2);

  // Monitor: observes handshakes and flag pulses away from the active edge.
  logic [7:0] got_q[$];
  int         ferr_cnt     = 0;
  int         ovr_cnt      = 0;
  int         both_cnt     = 0;
  int         unstable_cnt = 0;
  bit         cs_seen      = 0;
  bit         held         = 0;
  logic [7:0] held_data;

  always @(negedge clk) begin
    if (rx_valid && rx_ready) got_q.push_back(rx_data);
    if (frame_err) ferr_cnt++;
    if (overrun) ovr_cnt++;
    if (frame_err && overrun) both_cnt++;
    if (count_sig) cs_seen = 1;
    if (held && rx_valid && rx_data !== held_data) unstable_cnt++;
    held      = rx_valid && !rx_ready;
    held_data = rx_data;
  end

  initial begin
    #(90_000 * 10);
    $display("FAIL watchdog: simulation still running at %0t, limit 900000", $time);
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Drives one 8N1 frame; abort_bit>=0 stops halfway through that data bit.
  task automatic send_frame(input logic [7:0] data, input bit stop_bit,
                            input int abort_bit, input bit leave_low);
    int bit_clks = bps_full + 1;
    rx_pin = 1'b0;
    tick(bit_clks);
    for (int i = 0; i < 8; i++) begin
      rx_pin = data[i];
      if (i == abort_bit) begin
        tick(bit_clks / 2);
        return;
      end
      tick(bit_clks);
    end
    rx_pin = stop_bit;
    tick(bit_clks);
    if (!leave_low) rx_pin = 1'b1;
  endtask

  typedef struct {
    logic [7:0] data;
    bit         stop_bit;
    bit         ready;
    int         exp_n;
    logic [7:0] exp_data;
    int         exp_ferr;
    int         exp_ovr;
  } vec_t;

  vec_t vecs[6];

  initial begin
    int base, f0, o0;
    logic [7:0] exp_q[$];
    logic [7:0] slot;
    bit         slot_full;
    int         exp_ferr, exp_ovr;

    vecs[0] = '{8'h55, 1'b1, 1'b1, 1, 8'h55, 0, 0};
    vecs[1] = '{8'hA3, 1'b0, 1'b1, 0, 8'h00, 1, 0};
    vecs[2] = '{8'h3C, 1'b1, 1'b1, 1, 8'h3C, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1'b1, 1, 8'h00, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1'b1, 1, 8'hFF, 0, 0};
    vecs[5] = '{8'h80, 1'b1, 1'b1, 1, 8'h80, 0, 0};

    rst_n    = 1'b0;
    rx_pin   = 1'b1;
    rx_ready = 1'b0;
    tick(5);
    check("reset_outputs", {count_sig, rx_valid, frame_err, overrun, rx_data}, 32'h0);
    rst_n = 1'b1;
    tick(5);
    check("idle_after_reset", {count_sig, rx_valid}, 32'h0);

    // Table: single frames, framing error, recovery and back-to-back bytes.
    for (int v = 0; v < 6; v++) begin
      base     = got_q.size();
      f0       = ferr_cnt;
      o0       = ovr_cnt;
      rx_ready = vecs[v].ready;
      send_frame(vecs[v].data, vecs[v].stop_bit, -1, 0);
      tick(3);
      check($sformatf("vec%0d_count", v), got_q.size() - base, vecs[v].exp_n);
      if (vecs[v].exp_n == 1 && got_q.size() > base)
        check($sformatf("vec%0d_data", v), got_q[base], vecs[v].exp_data);
      check($sformatf("vec%0d_ferr", v), ferr_cnt - f0, vecs[v].exp_ferr);
      check($sformatf("vec%0d_ovr", v), ovr_cnt - o0, vecs[v].exp_ovr);
      check($sformatf("vec%0d_count_sig", v), count_sig, 1'b0);
      check($sformatf("vec%0d_valid_clear", v), rx_valid, 1'b0);
    end

    // Short low glitch: counter runs, start sample sees high, back to idle.
    base    = got_q.size();
    f0      = ferr_cnt;
    cs_seen = 0;
    rx_pin  = 1'b0;
    tick(100);
    rx_pin = 1'b1;
    check("glitch_count_sig_rose", cs_seen, 1'b1);
    for (int i = 0; i < 1000 && count_sig; i++) tick(1);
    check("glitch_count_sig_fell", count_sig, 1'b0);
    check("glitch_no_byte", got_q.size() - base, 0);
    check("glitch_no_ferr", ferr_cnt - f0, 0);

    // Consumer stalled: second frame overruns, first byte held.
    base     = got_q.size();
    o0       = ovr_cnt;
    rx_ready = 1'b0;
    send_frame(8'h11, 1'b1, -1, 0);
    tick(3);
    check("stall_valid", rx_valid, 1'b1);
    check("stall_data", rx_data, 8'h11);
    send_frame(8'h22, 1'b1, -1, 0);
    tick(3);
    check("overrun_pulse", ovr_cnt - o0, 1);
    check("overrun_data_kept", rx_data, 8'h11);
    check("overrun_valid_kept", rx_valid, 1'b1);
    rx_ready = 1'b1;
    tick(3);
    check("drain_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("drain_data", got_q[base], 8'h11);
    check("drain_valid_clear", rx_valid, 1'b0);

    // Reset mid-frame: partial 0xF0 is lost, 0x0F arrives.
    base = got_q.size();
    send_frame(8'hF0, 1'b1, 4, 0);
    rst_n = 1'b0;
    tick(2);
    check("midframe_reset_outputs", {count_sig, rx_valid, frame_err, overrun, rx_data}, 32'h0);
    rx_pin = 1'b1;
    tick(10);
    rst_n = 1'b1;
    tick(5);
    send_frame(8'h0F, 1'b1, -1, 0);
    tick(3);
    check("post_reset_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("post_reset_data", got_q[base], 8'h0F);

    // Break: line stays low after a framing error, no new frame until it returns high.
    bps_full = 31;
    base     = got_q.size();
    f0       = ferr_cnt;
    send_frame(8'hA5, 1'b0, -1, 1);
    tick(2);
    cs_seen = 0;
    tick(96);
    check("break_ferr", ferr_cnt - f0, 1);
    check("break_no_count_sig", cs_seen, 1'b0);
    rx_pin = 1'b1;
    tick(10);
    send_frame(8'h5A, 1'b1, -1, 0);
    tick(3);
    check("after_break_count", got_q.size() - base, 1);
    if (got_q.size() > base) check("after_break_data", got_q[base], 8'h5A);

    // Random frames against a single-slot buffer model.
    base      = got_q.size();
    f0        = ferr_cnt;
    o0        = ovr_cnt;
    slot_full = 0;
    slot      = 8'h00;
    exp_ferr  = 0;
    exp_ovr   = 0;
    for (int n = 0; n < 30; n++) begin
      logic [7:0] d;
      bit         r, stop;
      r = 1'($urandom_range(0, 1));
      d = 8'($urandom);
      stop = ($urandom_range(0, 4) != 0);
      rx_ready = r;
      if (r && slot_full) begin
        exp_q.push_back(slot);
        slot_full = 0;
      end
      send_frame(d, stop, -1, 0);
      tick($urandom_range(2, 20));
      if (!stop) exp_ferr++;
      else if (slot_full) exp_ovr++;
      else if (r) exp_q.push_back(d);
      else begin
        slot      = d;
        slot_full = 1;
      end
    end
    rx_ready = 1'b1;
    if (slot_full) exp_q.push_back(slot);
    tick(5);
    check("rand_count", got_q.size() - base, exp_q.size());
    for (int i = 0; i < exp_q.size() && base + i < got_q.size(); i++)
      check($sformatf("rand_byte%0d", i), got_q[base + i], exp_q[i]);
    check("rand_ferr", ferr_cnt - f0, exp_ferr);
    check("rand_ovr", ovr_cnt - o0, exp_ovr);

    check("flags_never_together", both_cnt, 0);
    check("data_stable_while_held", unstable_cnt, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
